// File: rtl/pipelined_controller_pkg.sv
// Shared opcode, control-bundle and MDU types for the ID-stage controller.
// NOP_* bundles are the pipeline bubble: no register write, no store, no branch/jump.
package pipelined_controller_pkg;

  typedef enum logic [4:0] {
    LOAD    = 5'b00000,
    I_CALC  = 5'b00100,
    AUIPC   = 5'b00101,
    S_TYPE  = 5'b01000,
    R_TYPE  = 5'b01100,
    LUI     = 5'b01101,
    SB_TYPE = 5'b11000,
    JALR    = 5'b11001,
    UJ_TYPE = 5'b11011
  } opcode_t;

  localparam logic FUN7_M = 1'b1;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [2:0] {
    IMMGEN_I = 3'd0,
    IMMGEN_S = 3'd1,
    IMMGEN_B = 3'd2,
    IMMGEN_U = 3'd3,
    IMMGEN_J = 3'd4
  } imm_sel_t;

  typedef enum logic {ALU_RS2 = 1'b0, ALU_IMM = 1'b1} alu_src_b_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_ctrl_t;

  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_rw_t;

  typedef enum logic [1:0] {
    MEMTOREG_ALU = 2'd0,
    MEMTOREG_MEM = 2'd1,
    MEMTOREG_PC4 = 2'd2,
    MEMTOREG_MDU = 2'd3
  } memto_reg_t;

  typedef enum logic {REG_NO_WRITE = 1'b0, REG_WRITE = 1'b1} reg_write_t;

  typedef struct packed {
    imm_sel_t imm_sel;
  } id_control_t;

  typedef struct packed {
    alu_src_b_t alu_src_b;
    alu_ctrl_t  alu_control;
    logic       branch;
    logic       inverse_branch;
    logic       pc_offset;
  } ex_control_t;

  typedef struct packed {
    mem_rw_t    mem_rw;
    logic [2:0] rw_type;
    logic       jump;
  } mem_control_t;

  typedef struct packed {
    memto_reg_t memto_reg;
    reg_write_t reg_write;
  } wb_control_t;

  localparam id_control_t  NOP_ID_CTRL  = '{imm_sel: IMMGEN_I};
  localparam ex_control_t  NOP_EX_CTRL  = '{alu_src_b: ALU_RS2, alu_control: ALU_ADD,
                                            branch: 1'b0, inverse_branch: 1'b0, pc_offset: 1'b0};
  localparam mem_control_t NOP_MEM_CTRL = '{mem_rw: MEM_READ, rw_type: 3'b000, jump: 1'b0};
  localparam wb_control_t  NOP_WB_CTRL  = '{memto_reg: MEMTOREG_ALU, reg_write: REG_NO_WRITE};

  // alt selects SUB for fun3=000 and SRA for fun3=101; ignored elsewhere
  function automatic alu_ctrl_t alu_from_fun3(input logic [2:0] f3, input logic alt);
    alu_ctrl_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipelined_controller_base_decoder.sv
// Combinational RV32I main decode into id/ex/mem/wb bundles, zero latency, no flow control.
// Bubbles (valid_in=0) and unknown opcodes decode to NOP; unknown opcodes also raise illegal.
module base_decoder
  import pipelined_controller_pkg::*;
(
  input  logic         valid_in,
  input  opcode_t      opcode,
  input  logic [2:0]   fun3,
  input  logic         fun7,
  output id_control_t  id_ctrl,
  output ex_control_t  ex_ctrl,
  output mem_control_t mem_ctrl,
  output wb_control_t  wb_ctrl,
  output logic         illegal
);

  always_comb begin
    id_ctrl  = NOP_ID_CTRL;
    ex_ctrl  = NOP_EX_CTRL;
    mem_ctrl = NOP_MEM_CTRL;
    wb_ctrl  = NOP_WB_CTRL;
    illegal  = 1'b0;
    if (valid_in) begin
      case (opcode)
        R_TYPE: begin
          ex_ctrl.alu_control = alu_from_fun3(fun3, fun7);
          wb_ctrl.reg_write   = REG_WRITE;
        end
        I_CALC: begin
          id_ctrl.imm_sel     = IMMGEN_I;
          ex_ctrl.alu_src_b   = ALU_IMM;
          // fun7 is an immediate bit except on SRAI
          ex_ctrl.alu_control = alu_from_fun3(fun3, fun7 && (fun3 == 3'b101));
          wb_ctrl.reg_write   = REG_WRITE;
        end
        LOAD: begin
          id_ctrl.imm_sel   = IMMGEN_I;
          ex_ctrl.alu_src_b = ALU_IMM;
          mem_ctrl.rw_type  = fun3;
          wb_ctrl.memto_reg = MEMTOREG_MEM;
          wb_ctrl.reg_write = REG_WRITE;
        end
        JALR: begin
          id_ctrl.imm_sel   = IMMGEN_I;
          ex_ctrl.alu_src_b = ALU_IMM;
          mem_ctrl.jump     = 1'b1;
          wb_ctrl.memto_reg = MEMTOREG_PC4;
          wb_ctrl.reg_write = REG_WRITE;
        end
        S_TYPE: begin
          id_ctrl.imm_sel   = IMMGEN_S;
          ex_ctrl.alu_src_b = ALU_IMM;
          mem_ctrl.mem_rw   = MEM_WRITE;
          mem_ctrl.rw_type  = fun3;
        end
        SB_TYPE: begin
          id_ctrl.imm_sel        = IMMGEN_B;
          ex_ctrl.branch         = 1'b1;
          ex_ctrl.inverse_branch = fun3[0];
          if (!fun3[2])     ex_ctrl.alu_control = ALU_SUB;
          else if (fun3[1]) ex_ctrl.alu_control = ALU_SLTU;
          else              ex_ctrl.alu_control = ALU_SLT;
        end
        UJ_TYPE: begin
          id_ctrl.imm_sel   = IMMGEN_J;
          ex_ctrl.alu_src_b = ALU_IMM;
          ex_ctrl.pc_offset = 1'b1;
          mem_ctrl.jump     = 1'b1;
          wb_ctrl.memto_reg = MEMTOREG_PC4;
          wb_ctrl.reg_write = REG_WRITE;
        end
        LUI: begin
          id_ctrl.imm_sel     = IMMGEN_U;
          ex_ctrl.alu_src_b   = ALU_IMM;
          ex_ctrl.alu_control = ALU_LUI;
          wb_ctrl.reg_write   = REG_WRITE;
        end
        AUIPC: begin
          id_ctrl.imm_sel   = IMMGEN_U;
          ex_ctrl.alu_src_b = ALU_IMM;
          ex_ctrl.pc_offset = 1'b1;
          wb_ctrl.reg_write = REG_WRITE;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_controller.sv
// ID-stage controller: RV32I decode plus RV32M sequencing; a multi-cycle M op stalls ID for LAT
// cycles (NOP bundles downstream) then issues its bundle with mdu_start; ex_flush kills ID at once.
module pipelined_controller
  import pipelined_controller_pkg::*;
#(
  parameter int ENABLE_M    = 1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  opcode_t      opcode,
  input  logic [2:0]   fun3,
  input  logic         fun7,
  input  logic         fun7_m,
  input  logic         ex_flush,
  output id_control_t  id_ctrl,
  output ex_control_t  ex_ctrl,
  output mem_control_t mem_ctrl,
  output wb_control_t  wb_ctrl,
  output logic         stall_id,
  output logic         mdu_start,
  output mdu_op_t      mdu_op,
  output logic         illegal
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam bit M_ON    = (ENABLE_M != 0);

  localparam ex_control_t  M_EX_CTRL  = '{alu_src_b: ALU_RS2, alu_control: ALU_ADD,
                                          branch: 1'b0, inverse_branch: 1'b0, pc_offset: 1'b0};
  localparam mem_control_t M_MEM_CTRL = '{mem_rw: MEM_READ, rw_type: 3'b000, jump: 1'b0};
  localparam wb_control_t  M_WB_CTRL  = '{memto_reg: MEMTOREG_MDU, reg_write: REG_WRITE};

  typedef enum logic [1:0] {IDLE, BUSY, ISSUE} ctrl_state_t;

  ctrl_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] lat;
  logic          m_enc, m_op, m_illegal, base_illegal, pass;

  id_control_t  base_id,  dec_id;
  ex_control_t  base_ex,  dec_ex;
  mem_control_t base_mem, dec_mem;
  wb_control_t  base_wb,  dec_wb;

  base_decoder u_base_decoder (
    .valid_in (valid_in),
    .opcode   (opcode),
    .fun3     (fun3),
    .fun7     (fun7),
    .id_ctrl  (base_id),
    .ex_ctrl  (base_ex),
    .mem_ctrl (base_mem),
    .wb_ctrl  (base_wb),
    .illegal  (base_illegal)
  );

  assign m_enc     = valid_in && (opcode == R_TYPE) && (fun7_m == FUN7_M);
  assign m_op      = m_enc && M_ON;
  assign m_illegal = m_enc && !M_ON;
  assign illegal   = base_illegal || m_illegal;
  assign lat       = fun3[2] ? CW'(DIV_LATENCY) : CW'(MUL_LATENCY);

  always_comb begin
    dec_id  = base_id;
    dec_ex  = base_ex;
    dec_mem = base_mem;
    dec_wb  = base_wb;
    if (m_op) begin
      dec_id  = NOP_ID_CTRL;
      dec_ex  = M_EX_CTRL;
      dec_mem = M_MEM_CTRL;
      dec_wb  = M_WB_CTRL;
    end else if (m_illegal) begin
      dec_id  = NOP_ID_CTRL;
      dec_ex  = NOP_EX_CTRL;
      dec_mem = NOP_MEM_CTRL;
      dec_wb  = NOP_WB_CTRL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_id  = 1'b0;
    mdu_start = 1'b0;
    pass      = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (ex_flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_op && (lat != '0)) begin
            stall_id  = 1'b1;
            cnt_nxt   = lat - CW'(1);
            state_nxt = (lat == CW'(1)) ? ISSUE : BUSY;
          end else begin
            // zero-latency M ops issue in the decode cycle itself
            pass      = 1'b1;
            mdu_start = m_op;
          end
        end
        BUSY: begin
          stall_id = 1'b1;
          cnt_nxt  = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = ISSUE;
        end
        ISSUE: begin
          pass      = 1'b1;
          mdu_start = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign id_ctrl  = pass ? dec_id  : NOP_ID_CTRL;
  assign ex_ctrl  = pass ? dec_ex  : NOP_EX_CTRL;
  assign mem_ctrl = pass ? dec_mem : NOP_MEM_CTRL;
  assign wb_ctrl  = pass ? dec_wb  : NOP_WB_CTRL;
  assign mdu_op   = mdu_start ? mdu_op_t'(fun3) : MUL;

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Next-generation ID-stage main decoder. It decodes RV32I into id/ex/mem/wb control bundles, like the current combinational decoder.
- Adds optional RV32M decode and a sequencer for multi-cycle multiply/divide in EX.
- While an M op runs, it holds the instruction in ID by raising stall_id and driving NOP bundles downstream. It then issues the real bundle with a start pulse to the MDU.
- Flags illegal opcodes.

Parameters:
- ENABLE_M, 1, 1 = decode RV32M; 0 = M encodings (R-type, instr[25]=1) are illegal.
- MUL_LATENCY, 2, EX cycles for MUL/MULH/MULHSU/MULHU; 0 = single-cycle, no stall.
- DIV_LATENCY, 33, EX cycles for DIV/DIVU/REM/REMU; 0 = single-cycle, no stall.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  ID holds a real (non-bubble) instruction.
- opcode  in  opcode_t(5)  instruction[6:2].
- fun3  in  3  instruction[14:12].
- fun7  in  1  instruction[30].
- fun7_m  in  1  instruction[25] (M-extension select).
- ex_flush  in  1  taken branch/jump redirect; kills ID.
- id_ctrl  out  id_control_t  ImmSel etc.
- ex_ctrl  out  ex_control_t  ALUSrcB, ALUControl, Branch, InverseBranch, PCOffset.
- mem_ctrl  out  mem_control_t  MemRW, RWType, Jump.
- wb_ctrl  out  wb_control_t  MemtoReg, RegWrite.
- stall_id  out  1  freeze PC/IF/ID registers.
- mdu_start  out  1  one-cycle pulse to the MDU, aligned with the issued bundle.
- mdu_op  out  3  fun3 of the issued M op; valid when mdu_start=1.
- illegal  out  1  valid_in and the opcode/encoding is not supported.

Behaviour:
- Base decode is combinational from the inputs and matches the current RV32I controller exactly (R, I-calc, LOAD, JALR, S, SB, UJ, LUI, AUIPC).
  - For an unknown opcode: all four bundles are NOP_*_CTRL and illegal=1.
  - When valid_in=0: bundles are NOP and illegal=0.
- M op: valid_in & ENABLE_M & opcode==R_TYPE & fun7_m. Its latency is LAT = fun3[2] ? DIV_LATENCY : MUL_LATENCY.
- M op bundle:
  - ALUSrcB=ALU_RS2.
  - RegWrite=REG_WRITE.
  - MemtoReg=MEMTOREG_MDU (new enum value).
  - MemRW=MEM_READ.
  - ALUControl is don't-care and driven as ALU_ADD.
- FSM states: IDLE, BUSY, ISSUE. The state register and cnt register ($clog2(max(MUL,DIV)+1) bits) are asynchronously reset to IDLE/0.
- IDLE:
  - M op with LAT>0 and !ex_flush: stall_id=1, bundles NOP, cnt<=LAT-1, go BUSY. If LAT==1, go directly to ISSUE.
  - M op with LAT==0: issue immediately (mdu_start=1, real bundle, no stall).
  - Anything else: pass the decode through, stall_id=0.
- BUSY: stall_id=1, bundles NOP. Decrement cnt; when cnt==1, go ISSUE.
- ISSUE: stall_id=0, real M bundle, mdu_start=1, mdu_op=fun3. Go IDLE next cycle.
- Net effect: an M op with LAT=L holds ID for exactly L stall cycles followed by one issue cycle. The MDU result is consumed L cycles after mdu_start by the team's EX/MEM register alignment.
- ex_flush in any state:
  - Outputs this cycle: bundles NOP, mdu_start=0, stall_id=0.
  - Next state is IDLE, cnt<=0.
  - Flush beats a simultaneous M-op detect in IDLE.
- Combinational outputs are stall_id, mdu_start, mdu_op and the bundles. They are functions of state and inputs only, and they are NOP/0 during reset assertion.
- rst asserted mid-BUSY: return to IDLE on the asserting edge, with no mdu_start ever issued. After release, the still-present M op restarts from a full count.
- Inputs are assumed stable while stall_id=1, since upstream holds ID. A bench assertion checks this.

Decomposition:
- Into control_signal_types.sv: MEMTOREG_MDU, mdu_op_t (MUL..REMU as fun3).
- Into instruction_types.sv: FUN7_M constant.
- FSM state typedef ctrl_state_t stays local.
- One sub-module: base_decoder, the combinational RV32I decode with an illegal flag. pipelined_controller instantiates it and adds the M-ext decode, FSM, counter and NOP muxing.

Test Plan:
- Reset: rst=1 mid-stream -> stall_id=0, mdu_start=0, all bundles NOP. Release with ADDI x1,x0,5 -> ImmSel=IMMGEN_I, ALUSrcB=ALU_IMM, RegWrite=1 the same cycle.
- MUL, MUL_LATENCY=2: valid M op at cycle 0 -> stall_id=1 on cycles 0-1 with NOP bundles. Cycle 2: stall_id=0, mdu_start=1, mdu_op=3'b000, MemtoReg=MEMTOREG_MDU. Cycle 3: IDLE.
- DIVU, DIV_LATENCY=33 -> exactly 33 stall cycles, then one mdu_start with mdu_op=3'b101. No second pulse.
- ex_flush asserted in cycle 10 of a DIV -> that cycle stall_id=0, NOP. Next cycle IDLE. No mdu_start observed.
- ENABLE_M=0 with MUL encoding -> illegal=1, NOP bundles, no stall. Opcode 5'b11111 -> illegal=1. valid_in=0 with that opcode -> illegal=0.
- MUL_LATENCY=0: MUL -> same-cycle mdu_start=1, stall_id never high. Async rst pulse mid-BUSY -> immediate IDLE; the M op then restarts a full count.
